tmr_error_monitor: RTL and testbench
====================================

Name: tmr_error_monitor

Overview:
- Receiving end of a triplicated bus. Takes the three copies A/B/C of a WIDTH-bit signal from a triplicated slice.
- Produces a registered majority-voted value and per-copy mismatch pulses.
- Keeps saturating per-copy error counters and a per-copy health state machine (OK/SUSPECT/FAULTY).
- Sits between triplicated logic and single-domain consumers, e.g. slow control or status readout, and feeds scrubbing and diagnostics.

Parameters:
- WIDTH, 2, width of each triplicated copy.
- CNT_WIDTH, 8, width of each per-copy error counter.
- FAULT_THRESH, 4, consecutive mismatching cycles that move a copy from SUSPECT to FAULTY; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- inA  input  WIDTH  copy A.
- inB  input  WIDTH  copy B.
- inC  input  WIDTH  copy C.
- clear  input  1  synchronous clear of counters, sticky flags and health states.
- out  output  WIDTH  registered voted value.
- errA  output  1  registered pulse: copy A disagreed with the vote.
- errB  output  1  registered pulse: copy B disagreed with the vote.
- errC  output  1  registered pulse: copy C disagreed with the vote.
- uncorr  output  1  registered pulse: all three copies pairwise different.
- cntA  output  CNT_WIDTH  saturating mismatch count for copy A.
- cntB  output  CNT_WIDTH  saturating mismatch count for copy B.
- cntC  output  CNT_WIDTH  saturating mismatch count for copy C.
- healthA  output  2  health state of copy A: 0 OK, 1 SUSPECT, 2 FAULTY.
- healthB  output  2  health state of copy B, same encoding.
- healthC  output  2  health state of copy C, same encoding.
- anyErr  output  1  sticky: any mismatch since reset or clear.

Behaviour:
- Reset value of every output: out=0, all err pulses=0, uncorr=0, counters=0, health=OK, anyErr=0. Reset asserted mid-operation clears everything immediately, without waiting for clk.
- Vote, combinational: voted = (inA&inB)|(inB&inC)|(inA&inC), bitwise.
- mA = |(inA^voted); mB and mC are formed the same way.
- u = (inA!=inB)&&(inB!=inC)&&(inA!=inC).
- Latency: out, errX and uncorr equal the cycle-N values at edge N+1, i.e. one-cycle latency. Pulses are high for exactly the cycles that mismatched.
- Counter X: increments by 1 on each cycle with mX=1 and saturates at 2^CNT_WIDTH-1 (no wrap).
- anyErr: set when mA|mB|mC.
- Per-copy FSM, with a consecutive-mismatch counter run (8-bit):
  - OK: mX=1 -> SUSPECT, run=1; mX=0 -> stay.
  - SUSPECT: mX=0 -> OK, run=0. mX=1 -> run+1; when run+1 == FAULT_THRESH -> FAULTY.
  - FAULTY: absorbing until clear or rst; counter keeps counting.
- Net effect: FAULTY is entered on the FAULT_THRESH-th consecutive mismatch cycle, visible on healthX one edge later.
- clear: same-cycle priority over increment, set and FSM transitions. Counters=0, run=0, health=OK, anyErr=0. out, errX and uncorr are not affected by clear (they still reflect that cycle's inputs).
- Simultaneous mismatch of two copies: only possible with WIDTH>1 and different bits. Each copy is accounted independently.
- uncorr does not suppress errX.

Test Plan:
- Reset then inA=inB=inC=2'b10 for 5 cycles -> out=2'b10 after 1 edge; no err pulses; counters 0; health all OK.
- inA=2'b01, inB=inC=2'b10 for 1 cycle -> out=2'b10, errA one-cycle pulse, cntA=1, healthA=SUSPECT, then OK after next matching cycle; anyErr stays 1.
- inC mismatching 4 consecutive cycles (FAULT_THRESH=4) -> healthC=1,1,1,2; stays 2 after inputs match; cntC=4.
- inA=00, inB=01, inC=10 -> voted 00, uncorr=1, errB=errC=1, errA=0.
- CNT_WIDTH=8, copy B mismatching 300 cycles -> cntB holds 255. clear asserted in a mismatch cycle -> cntB=0, healthB=OK, anyErr=0 next edge.
- Async rst asserted between edges during FAULTY -> all outputs 0 and health OK before the next clk edge.

Source files
------------

// File: rtl/tmr_error_monitor.sv
// tmr_error_monitor
// Receiving end of a triplicated bus. Votes the three copies bitwise,
// registers the voted value together with per-copy mismatch pulses and an
// uncorrectable flag, and tracks per-copy error statistics: a saturating
// mismatch counter and an OK/SUSPECT/FAULTY health state machine.
// rst is asynchronous active-high; clear is a synchronous wipe of the
// statistics (counters, run lengths, health, sticky anyErr) only.

module tmr_error_monitor #(
    parameter int WIDTH        = 2,
    parameter int CNT_WIDTH    = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 clear,
    output logic [WIDTH-1:0]     out,
    output logic                 errA,
    output logic                 errB,
    output logic                 errC,
    output logic                 uncorr,
    output logic [CNT_WIDTH-1:0] cntA,
    output logic [CNT_WIDTH-1:0] cntB,
    output logic [CNT_WIDTH-1:0] cntC,
    output logic [1:0]           healthA,
    output logic [1:0]           healthB,
    output logic [1:0]           healthC,
    output logic                 anyErr
);

    typedef enum logic [1:0] {
        H_OK      = 2'd0,
        H_SUSPECT = 2'd1,
        H_FAULTY  = 2'd2
    } health_t;

    localparam logic [7:0]           THRESH  = FAULT_THRESH[7:0];
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    // Bitwise two-out-of-three majority.
    function automatic logic [WIDTH-1:0] vote3(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        return (a & b) | (b & c) | (a & c);
    endfunction

    logic [WIDTH-1:0]     copy_s [3];
    logic [WIDTH-1:0]     voted_s;
    logic [2:0]           mis_s;
    logic                 uncorr_s;

    logic [WIDTH-1:0]     out_q;
    logic [2:0]           err_q;
    logic                 uncorr_q;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];
    logic                 any_err_q;
    logic                 any_err_d;
    health_t              health_q [3];
    logic [7:0]           run_q [3];

    // Vote, per-copy mismatch detection and the all-different condition.
    always_comb begin
        copy_s[0] = inA;
        copy_s[1] = inB;
        copy_s[2] = inC;
        voted_s   = vote3(inA, inB, inC);
        mis_s     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            mis_s[i] = |(copy_s[i] ^ voted_s);
        end
        uncorr_s = (inA != inB) && (inB != inC) && (inA != inC);
    end

    // Next values of the saturating counters and sticky flag; clear wins.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                cnt_d[i] = CNT_ZERO;
            end else if (mis_s[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        if (clear) begin
            any_err_d = 1'b0;
        end else begin
            any_err_d = any_err_q | (|mis_s);
        end
    end

    // Register the voted value, pulses, counters and sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= {WIDTH{1'b0}};
            err_q     <= 3'b000;
            uncorr_q  <= 1'b0;
            any_err_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            out_q     <= voted_s;
            err_q     <= mis_s;
            uncorr_q  <= uncorr_s;
            any_err_q <= any_err_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Per-copy health FSM driven by the consecutive-mismatch run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                health_q[i] <= H_OK;
                run_q[i]    <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clear) begin
                    health_q[i] <= H_OK;
                    run_q[i]    <= 8'd0;
                end else begin
                    case (health_q[i])
                        H_OK: begin
                            if (mis_s[i]) begin
                                health_q[i] <= H_SUSPECT;
                                run_q[i]    <= 8'd1;
                            end else begin
                                health_q[i] <= H_OK;
                            end
                        end
                        H_SUSPECT: begin
                            if (!mis_s[i]) begin
                                health_q[i] <= H_OK;
                                run_q[i]    <= 8'd0;
                            end else if ((run_q[i] + 8'd1) == THRESH) begin
                                health_q[i] <= H_FAULTY;
                                run_q[i]    <= run_q[i] + 8'd1;
                            end else begin
                                health_q[i] <= H_SUSPECT;
                                run_q[i]    <= run_q[i] + 8'd1;
                            end
                        end
                        H_FAULTY: begin
                            // Absorbing until clear or reset.
                            health_q[i] <= H_FAULTY;
                        end
                        default: begin
                            health_q[i] <= H_OK;
                            run_q[i]    <= 8'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign out     = out_q;
    assign errA    = err_q[0];
    assign errB    = err_q[1];
    assign errC    = err_q[2];
    assign uncorr  = uncorr_q;
    assign cntA    = cnt_q[0];
    assign cntB    = cnt_q[1];
    assign cntC    = cnt_q[2];
    assign healthA = health_q[0];
    assign healthB = health_q[1];
    assign healthC = health_q[2];
    assign anyErr  = any_err_q;

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Scoreboard bench for tmr_error_monitor: the driver applies directed
// vectors on the falling edge and queues the hand-computed outputs expected
// after the next rising edge; a monitor pops and compares after each edge.

module tb_tmr_error_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] inA, inB, inC;
    logic       clear;
    logic [1:0] out;
    logic       errA, errB, errC, uncorr;
    logic [7:0] cntA, cntB, cntC;
    logic [1:0] healthA, healthB, healthC;
    logic       anyErr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] o;
        logic       ea, eb, ec, u;
        logic [7:0] ca, cb, cc;
        logic [1:0] ha, hb, hc;
        logic       any;
    } exp_t;

    exp_t sb[$];

    tmr_error_monitor #(.WIDTH(2), .CNT_WIDTH(8), .FAULT_THRESH(4)) dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC), .clear(clear),
        .out(out), .errA(errA), .errB(errB), .errC(errC), .uncorr(uncorr),
        .cntA(cntA), .cntB(cntB), .cntC(cntC),
        .healthA(healthA), .healthB(healthB), .healthC(healthC),
        .anyErr(anyErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, " out"},     32'(out),     32'(e.o));
        chk({tag, " errA"},    32'(errA),    32'(e.ea));
        chk({tag, " errB"},    32'(errB),    32'(e.eb));
        chk({tag, " errC"},    32'(errC),    32'(e.ec));
        chk({tag, " uncorr"},  32'(uncorr),  32'(e.u));
        chk({tag, " cntA"},    32'(cntA),    32'(e.ca));
        chk({tag, " cntB"},    32'(cntB),    32'(e.cb));
        chk({tag, " cntC"},    32'(cntC),    32'(e.cc));
        chk({tag, " healthA"}, 32'(healthA), 32'(e.ha));
        chk({tag, " healthB"}, 32'(healthB), 32'(e.hb));
        chk({tag, " healthC"}, 32'(healthC), 32'(e.hc));
        chk({tag, " anyErr"},  32'(anyErr),  32'(e.any));
    endtask

    // Apply one vector on the falling edge and queue its expected result.
    task automatic step(
        input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic clr,
        input logic [1:0] o, input logic ea, input logic eb, input logic ec, input logic u,
        input logic [7:0] ca, input logic [7:0] cb, input logic [7:0] cc,
        input logic [1:0] ha, input logic [1:0] hb, input logic [1:0] hc, input logic any
    );
        exp_t e;
        @(negedge clk);
        inA   = a;
        inB   = b;
        inC   = c;
        clear = clr;
        e = '{o: o, ea: ea, eb: eb, ec: ec, u: u, ca: ca, cb: cb, cc: cc,
              ha: ha, hb: hb, hc: hc, any: any};
        sb.push_back(e);
    endtask

    // Monitor: one rising edge later, compare outputs with the queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_all("sb", e);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t zero_e;
        zero_e = '0;
        rst   = 1'b1;
        inA   = 2'b00;
        inB   = 2'b00;
        inC   = 2'b00;
        clear = 1'b0;
        #3;
        check_all("reset", zero_e);
        @(negedge clk);
        rst = 1'b0;

        // All copies agree: clean vote, no statistics.
        for (int i = 0; i < 5; i++)
            step(2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 0,0,0,0, 8'd0,8'd0,8'd0, 2'd0,2'd0,2'd0, 1'b0);

        // Single-cycle glitch on A, then recovery to OK; anyErr sticks.
        step(2'b01, 2'b10, 2'b10, 1'b0, 2'b10, 1,0,0,0, 8'd1,8'd0,8'd0, 2'd1,2'd0,2'd0, 1'b1);
        step(2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 0,0,0,0, 8'd1,8'd0,8'd0, 2'd0,2'd0,2'd0, 1'b1);

        // C wrong for 4 consecutive cycles -> SUSPECT x3 then FAULTY, which sticks.
        step(2'b10, 2'b10, 2'b01, 1'b0, 2'b10, 0,0,1,0, 8'd1,8'd0,8'd1, 2'd0,2'd0,2'd1, 1'b1);
        step(2'b10, 2'b10, 2'b01, 1'b0, 2'b10, 0,0,1,0, 8'd1,8'd0,8'd2, 2'd0,2'd0,2'd1, 1'b1);
        step(2'b10, 2'b10, 2'b01, 1'b0, 2'b10, 0,0,1,0, 8'd1,8'd0,8'd3, 2'd0,2'd0,2'd1, 1'b1);
        step(2'b10, 2'b10, 2'b01, 1'b0, 2'b10, 0,0,1,0, 8'd1,8'd0,8'd4, 2'd0,2'd0,2'd2, 1'b1);
        step(2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 0,0,0,0, 8'd1,8'd0,8'd4, 2'd0,2'd0,2'd2, 1'b1);
        step(2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 0,0,0,0, 8'd1,8'd0,8'd4, 2'd0,2'd0,2'd2, 1'b1);

        // All pairwise different: vote 00, uncorr with errB/errC, errA quiet.
        step(2'b00, 2'b01, 2'b10, 1'b0, 2'b00, 0,1,1,1, 8'd1,8'd1,8'd5, 2'd0,2'd1,2'd2, 1'b1);
        step(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0,0,0,0, 8'd1,8'd1,8'd5, 2'd0,2'd0,2'd2, 1'b1);

        // Clear in a matching cycle wipes statistics only.
        step(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 0,0,0,0, 8'd0,8'd0,8'd0, 2'd0,2'd0,2'd0, 1'b0);

        // B wrong for 300 cycles: counter saturates at 255, FAULTY from cycle 4.
        for (int k = 1; k <= 300; k++)
            step(2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 0,1,0,0, 8'd0,
                 (k > 255) ? 8'd255 : 8'(k), 8'd0, 2'd0,
                 (k < 4) ? 2'd1 : 2'd2, 2'd0, 1'b1);

        // Clear during a mismatch cycle: pulses still reflect inputs.
        step(2'b11, 2'b00, 2'b11, 1'b1, 2'b11, 0,1,0,0, 8'd0,8'd0,8'd0, 2'd0,2'd0,2'd0, 1'b0);
        step(2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 0,1,0,0, 8'd0,8'd1,8'd0, 2'd0,2'd1,2'd0, 1'b1);
        step(2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 0,1,0,0, 8'd0,8'd2,8'd0, 2'd0,2'd1,2'd0, 1'b1);
        step(2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 0,1,0,0, 8'd0,8'd3,8'd0, 2'd0,2'd1,2'd0, 1'b1);
        step(2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 0,1,0,0, 8'd0,8'd4,8'd0, 2'd0,2'd2,2'd0, 1'b1);

        // Async reset between edges while B is FAULTY.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", zero_e);
        inA = 2'b00;
        inB = 2'b00;
        inC = 2'b00;
        #1;
        rst = 1'b0;
        step(2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 0,0,0,0, 8'd0,8'd0,8'd0, 2'd0,2'd0,2'd0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
